// File: rtl/showcase_ram_pipe.sv
// showcase_ram_pipe: write stream stored to RAM, address carried down a DELAY-stage valid pipeline,
// then read back on a valid/ready output. Optional RAM init FSM: SHOWCASE_RAM_PIPE_INIT_EN.
module showcase_ram_pipe #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned DELAY     = 2,
  parameter int unsigned CMP_CONST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  input  logic              sticky_in,
  output logic              sticky_out,
  output logic              cmp_lt,
  output logic              cmp_gt,
  output logic              cmp_eq,
  output logic [15:0]       acc_cnt
);

  localparam int unsigned       Depth  = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] CmpVal = DATA_W'(CMP_CONST);

  logic [DATA_W-1:0] mem [Depth];

  logic [DELAY-1:0]  stg_vld_q;
  logic [ADDR_W-1:0] stg_addr_q [DELAY];

  logic [DATA_W-1:0] out_data_q;
  logic              out_vld_q;
  logic              sticky_q;
  logic              cmp_lt_q, cmp_gt_q, cmp_eq_q;
  logic [15:0]       acc_cnt_q;

  logic advance;
  logic accept;
  logic run;

  assign advance = !out_vld_q || out_rdy;
  assign in_rdy  = run && advance && rst_n;
  assign accept  = in_vld && in_rdy;

`ifdef SHOWCASE_RAM_PIPE_INIT_EN
  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_we;

  assign run     = (state_q == StRun);
  assign init_we = rst_n && (state_q == StInit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else if (state_q == StInit) begin
      init_cnt_q <= init_cnt_q + ADDR_W'(1);
      if (init_cnt_q == ADDR_W'(Depth - 1)) begin
        state_q <= StRun;
      end
    end
  end

  // Init writes and stream writes are mutually exclusive: in_rdy is low during INIT.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt_q] <= DATA_W'(init_cnt_q);
    end else if (accept) begin
      mem[in_addr] <= in_data;
    end
  end
`else
  assign run = 1'b1;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[in_addr] <= in_data;
    end
  end
`endif

  // Valid chain and read-back register; reading mem here returns pre-write content on collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_vld_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (advance) begin
      for (int unsigned k = DELAY - 1; k >= 1; k--) begin
        stg_vld_q[k] <= stg_vld_q[k-1];
      end
      stg_vld_q[0] <= accept;
      out_vld_q    <= stg_vld_q[DELAY-1];
      if (stg_vld_q[DELAY-1]) begin
        out_data_q <= mem[stg_addr_q[DELAY-1]];
      end
    end
  end

  // Addresses are qualified by the valid chain, so they need no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int unsigned k = DELAY - 1; k >= 1; k--) begin
        stg_addr_q[k] <= stg_addr_q[k-1];
      end
      stg_addr_q[0] <= in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q  <= 1'b0;
      cmp_lt_q  <= 1'b0;
      cmp_gt_q  <= 1'b0;
      cmp_eq_q  <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      if (sticky_in) begin
        sticky_q <= 1'b1;
      end
      if (accept) begin
        cmp_lt_q <= (in_data < CmpVal);
        cmp_gt_q <= (in_data > CmpVal);
        cmp_eq_q <= (in_data == CmpVal);
        if (acc_cnt_q != 16'hFFFF) begin
          acc_cnt_q <= acc_cnt_q + 16'd1;
        end
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_vld    = out_vld_q;
  assign sticky_out = sticky_q;
  assign cmp_lt     = cmp_lt_q;
  assign cmp_gt     = cmp_gt_q;
  assign cmp_eq     = cmp_eq_q;
  assign acc_cnt    = acc_cnt_q;

`ifndef SYNTHESIS
  out_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    (out_vld_q && !out_rdy) |=> (out_vld_q && $stable(out_data_q)));

  cnt_mono_a: assert property (@(posedge clk) disable iff (!rst_n)
    1'b1 |=> (acc_cnt_q >= $past(acc_cnt_q)));

  cmp_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    (acc_cnt_q != 16'd0) |-> $onehot({cmp_lt_q, cmp_gt_q, cmp_eq_q}));
`endif

endmodule
